// File: rtl/field_compactor_fifo_if.sv
// Bus between the FAST field decoders / consumer (master) and the compacting FIFO (slave).
// Write lanes carry {valid, msg ID, beat index, payload}; read lanes are first-word-fall-through.
interface field_compactor_fifo_if #(
    parameter int unsigned NUM_DECODERS     = 4,
    parameter int unsigned BEAT_WIDTH       = 64,
    parameter int unsigned MAX_MESSAGE_SIZE = 10,
    parameter int unsigned MESSAGEID_SIZE   = 21,
    parameter int unsigned DEPTH            = 16,
    parameter int unsigned NUM_READ         = 2
);
    localparam int unsigned IW = $clog2(MAX_MESSAGE_SIZE);
    localparam int unsigned FW = MESSAGEID_SIZE + IW + BEAT_WIDTH;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(NUM_READ + 1);

    logic [NUM_DECODERS-1:0][FW:0] decoded_fields;
    logic                          in_ready;
    logic                          flush;
    logic [NUM_READ-1:0][FW-1:0]   out_fields;
    logic [NUM_READ-1:0]           out_valid;
    logic [PW-1:0]                 pop_count;
    logic [CW-1:0]                 count;
    logic                          overflow;
    logic                          underflow;
    logic [15:0]                   drop_count;

    modport master (
        output decoded_fields, flush, pop_count,
        input  in_ready, out_fields, out_valid, count, overflow, underflow, drop_count
    );

    modport slave (
        input  decoded_fields, flush, pop_count,
        output in_ready, out_fields, out_valid, count, overflow, underflow, drop_count
    );
endinterface

// File: rtl/field_compactor_fifo.sv
// Multi-port compacting FIFO: packs valid decoder lanes gap-free into a circular buffer
// and presents the oldest NUM_READ entries first-word-fall-through.
module field_compactor_fifo #(
    parameter int unsigned NUM_DECODERS     = 4,
    parameter int unsigned BEAT_WIDTH       = 64,
    parameter int unsigned MAX_MESSAGE_SIZE = 10,
    parameter int unsigned MESSAGEID_SIZE   = 21,
    parameter int unsigned DEPTH            = 16,
    parameter int unsigned NUM_READ         = 2
) (
    input logic                   clk,
    input logic                   rstn,
    field_compactor_fifo_if.slave bus
);
    localparam int unsigned IW = $clog2(MAX_MESSAGE_SIZE);
    localparam int unsigned FW = MESSAGEID_SIZE + IW + BEAT_WIDTH;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW:0]   cnt_t;

    logic [FW-1:0]           storage [DEPTH];
    ptr_t                    rd_ptr;
    ptr_t                    wr_ptr;
    logic [CW-1:0]           count_q;
    logic                    overflow_q;
    logic                    underflow_q;
    logic [15:0]             drop_q;

    logic [NUM_DECODERS-1:0] lane_valid;
    ptr_t                    lane_offset [NUM_DECODERS];
    cnt_t                    nw;
    cnt_t                    np;
    cnt_t                    count_next;
    logic                    ready;
    logic                    accept;
    logic                    drop;
    logic                    pop_over;
    logic [16:0]             drop_sum;

    // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
    always_comb begin
        nw = '0;
        for (int unsigned i = 0; i < NUM_DECODERS; i++) begin
            lane_valid[i]  = bus.decoded_fields[i][FW];
            lane_offset[i] = ptr_t'(nw);
            nw             = nw + cnt_t'(lane_valid[i]);
        end
    end

    assign ready      = (cnt_t'(DEPTH) - cnt_t'(count_q)) >= cnt_t'(NUM_DECODERS);
    assign pop_over   = cnt_t'(bus.pop_count) > cnt_t'(count_q);
    assign np         = pop_over ? cnt_t'(count_q) : cnt_t'(bus.pop_count);
    assign accept     = ready && !bus.flush;
    assign drop       = !ready && !bus.flush && (nw != '0);
    assign count_next = cnt_t'(count_q) + (accept ? nw : '0) - np;
    assign drop_sum   = 17'(drop_q) + 17'(nw);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            drop_q      <= '0;
        end else if (bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                for (int unsigned i = 0; i < NUM_DECODERS; i++) begin
                    if (lane_valid[i]) begin
                        storage[wr_ptr + lane_offset[i]] <= bus.decoded_fields[i][FW-1:0];
                    end
                end
                wr_ptr <= wr_ptr + ptr_t'(nw);
            end
            rd_ptr  <= rd_ptr + ptr_t'(np);
            count_q <= CW'(count_next);
            if (pop_over) begin
                underflow_q <= 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                drop_q     <= (drop_sum > 17'h0FFFF) ? 16'hFFFF : 16'(drop_sum);
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
    assign bus.drop_count = drop_q;

    always_comb begin
        bus.out_fields = '0;
        bus.out_valid  = '0;
        for (int unsigned i = 0; i < NUM_READ; i++) begin
            bus.out_fields[i] = storage[rd_ptr + ptr_t'(i)];
            bus.out_valid[i]  = cnt_t'(count_q) > cnt_t'(i);
        end
    end
endmodule

// File: tb/tb_field_compactor_fifo.sv
// Randomized bench for field_compactor_fifo: a queue-based reference model predicts popped
// fields into a scoreboard that a negedge monitor drains; status outputs are checked per cycle.
module tb_field_compactor_fifo;
    localparam int unsigned ND    = 4;
    localparam int unsigned BW    = 64;
    localparam int unsigned MMS   = 10;
    localparam int unsigned MID   = 21;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned NR    = 2;
    localparam int unsigned FW    = MID + $clog2(MMS) + BW;
    localparam int unsigned PW    = $clog2(NR + 1);

    typedef logic [FW-1:0] field_t;

    logic clk;
    logic rstn;

    field_compactor_fifo_if #(
        .NUM_DECODERS(ND), .BEAT_WIDTH(BW), .MAX_MESSAGE_SIZE(MMS),
        .MESSAGEID_SIZE(MID), .DEPTH(DEPTH), .NUM_READ(NR)
    ) bus ();

    field_compactor_fifo #(
        .NUM_DECODERS(ND), .BEAT_WIDTH(BW), .MAX_MESSAGE_SIZE(MMS),
        .MESSAGEID_SIZE(MID), .DEPTH(DEPTH), .NUM_READ(NR)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    field_t model[$];
    field_t sb[$];
    field_t lane_data[ND];
    bit     exp_over  = 1'b0;
    bit     exp_under = 1'b0;
    int     exp_drop  = 0;
    field_t mon_exp;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < ND; i++) begin
            lane_data[i] = field_t'({$urandom, $urandom, $urandom});
        end
    endtask

    task automatic set_id(input int lane, input int unsigned id);
        lane_data[lane][FW-1 -: MID] = MID'(id);
    endtask

    // Drive one cycle of stimulus, check status against the model, then advance the model.
    task automatic cycle(input logic [ND-1:0] v, input int unsigned pop, input logic fl);
        int unsigned       occ;
        int unsigned       np;
        int unsigned       nw;
        logic [NR-1:0]     ev;
        for (int i = 0; i < ND; i++) begin
            bus.decoded_fields[i] = {v[i], lane_data[i]};
        end
        bus.pop_count = PW'(pop);
        bus.flush     = fl;
        occ = model.size();
        for (int i = 0; i < NR; i++) ev[i] = (occ > i);
        check("count", 128'(bus.count), 128'(occ));
        check("in_ready", 128'(bus.in_ready), 128'(occ + ND <= DEPTH));
        check("out_valid", 128'(bus.out_valid), 128'(ev));
        check("overflow", 128'(bus.overflow), 128'(exp_over));
        check("underflow", 128'(bus.underflow), 128'(exp_under));
        check("drop_count", 128'(bus.drop_count), 128'(exp_drop));
        if (fl) begin
            model.delete();
        end else begin
            np = (pop < occ) ? pop : occ;
            if (pop > occ) exp_under = 1'b1;
            for (int k = 0; k < int'(np); k++) sb.push_back(model.pop_front());
            nw = $countones(v);
            if (occ + ND <= DEPTH) begin
                for (int i = 0; i < ND; i++) if (v[i]) model.push_back(lane_data[i]);
            end else if (nw > 0) begin
                exp_over = 1'b1;
                exp_drop = exp_drop + int'(nw);
                if (exp_drop > 65535) exp_drop = 65535;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every lane the consumer pops this cycle must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rstn && !bus.flush) begin
            for (int i = 0; i < NR; i++) begin
                if (i < int'(bus.pop_count) && bus.out_valid[i]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_lane%0d actual %0h required no entry", i, bus.out_fields[i]);
                    end else begin
                        mon_exp = sb.pop_front();
                        check("pop_data", 128'(bus.out_fields[i]), 128'(mon_exp));
                    end
                end
            end
        end
    end

    initial begin
        logic [ND-1:0] v;
        int            a;
        int            b;
        rstn               = 1'b0;
        bus.decoded_fields = '0;
        bus.flush          = 1'b0;
        bus.pop_count      = '0;
        for (int i = 0; i < ND; i++) lane_data[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        check("reset_out0", 128'(bus.out_fields[0]), 128'(0));

        // Four-wide write, IDs 1..4
        rand_lanes();
        for (int i = 0; i < ND; i++) set_id(i, i + 1);
        cycle(4'b1111, 0, 1'b0);
        check("t1_id0", 128'(bus.out_fields[0][FW-1 -: MID]), 128'(1));
        check("t1_id1", 128'(bus.out_fields[1][FW-1 -: MID]), 128'(2));
        cycle('0, 2, 1'b0);
        cycle('0, 2, 1'b0);

        // Sparse lanes compact: lane1 then lane3
        rand_lanes();
        set_id(1, 7);
        set_id(3, 9);
        cycle(4'b1010, 0, 1'b0);
        check("t2_id0", 128'(bus.out_fields[0][FW-1 -: MID]), 128'(7));
        check("t2_id1", 128'(bus.out_fields[1][FW-1 -: MID]), 128'(9));
        cycle('0, 2, 1'b0);

        // Fill to 13, then a dropped three-lane beat
        for (int r = 0; r < 3; r++) begin
            rand_lanes();
            cycle(4'b1111, 0, 1'b0);
        end
        rand_lanes();
        cycle(4'b0001, 0, 1'b0);
        check("t3_in_ready", 128'(bus.in_ready), 128'(0));
        rand_lanes();
        cycle(4'b0111, 0, 1'b0);
        check("t3_overflow", 128'(bus.overflow), 128'(1));
        check("t3_drops", 128'(bus.drop_count), 128'(3));
        check("t3_count", 128'(bus.count), 128'(13));

        // Drain to 1, then over-pop
        for (int r = 0; r < 6; r++) cycle('0, 2, 1'b0);
        cycle('0, 2, 1'b0);
        check("t5_underflow", 128'(bus.underflow), 128'(1));
        check("t5_count", 128'(bus.count), 128'(0));

        // Steady two-in two-out through several pointer wraps
        rand_lanes();
        cycle(4'b0011, 0, 1'b0);
        for (int r = 0; r < 40; r++) begin
            rand_lanes();
            a = $urandom_range(0, ND - 1);
            b = (a + 1 + $urandom_range(0, ND - 2)) % ND;
            v = '0;
            v[a] = 1'b1;
            v[b] = 1'b1;
            cycle(v, 2, 1'b0);
        end
        cycle('0, 2, 1'b0);

        // Concurrent write and pop at count 8
        for (int r = 0; r < 2; r++) begin
            rand_lanes();
            cycle(4'b1111, 0, 1'b0);
        end
        rand_lanes();
        cycle(4'b1111, 2, 1'b0);
        check("t5_count10", 128'(bus.count), 128'(10));

        // Flush at count 6 with writes and pops pending
        cycle('0, 2, 1'b0);
        cycle('0, 2, 1'b0);
        check("t6_count6", 128'(bus.count), 128'(6));
        rand_lanes();
        cycle(4'b1111, 2, 1'b1);
        check("t6_flush_count", 128'(bus.count), 128'(0));
        check("t6_flush_drops", 128'(bus.drop_count), 128'(3));

        // Random traffic, biased to fill and drop, occasional flush
        for (int r = 0; r < 400; r++) begin
            rand_lanes();
            cycle(ND'($urandom), $urandom_range(0, NR), ($urandom_range(0, 31) == 0));
        end
        for (int r = 0; r < 10; r++) cycle('0, NR, 1'b0);
        check("sb_drained", 128'(sb.size()), 128'(0));

        // Asynchronous reset with live contents, checked before any clock edge
        rand_lanes();
        cycle(4'b1111, 0, 1'b0);
        bus.decoded_fields = '0;
        bus.pop_count      = '0;
        #2;
        rstn = 1'b0;
        #1;
        check("rst_count", 128'(bus.count), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_overflow", 128'(bus.overflow), 128'(0));
        check("rst_underflow", 128'(bus.underflow), 128'(0));
        check("rst_drops", 128'(bus.drop_count), 128'(0));
        for (int i = 0; i < NR; i++) check("rst_out_fields", 128'(bus.out_fields[i]), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
